// File: rtl/uart_prog_loader.sv
// uart_prog_loader: write side of the UART programmer. Parses
//   SYNC_BYTE, target, CNT_L, CNT_H, CNT x 4-byte words (MSB first)
// from the UART RX byte stream and issues one write strobe per word to the
// instruction (target 0) or data (target 1) memory.
//
// Optional feature macro: UPG_TIMEOUT_EN. When defined, an inter-byte gap of
// TIMEOUT_CYC cycles inside a packet aborts it into the error state.
//
// Ports:
//   clock       system clock, posedge
//   reset       asynchronous, active-high
//   rx_valid_i  1-cycle strobe, rx_data_i holds a received byte
//   rx_data_i   received byte
//   upg_wen_o   1-cycle memory write strobe
//   upg_adr_o   {target, word address}
//   upg_dat_o   write data
//   upg_done_o  last packet fully written, memories released to the CPU
//   err_o       sticky error flag (bad target, count overflow, timeout)
module uart_prog_loader #(
    parameter int unsigned ADDR_W      = 14,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              upg_wen_o,
    output logic [ADDR_W:0]   upg_adr_o,
    output logic [31:0]       upg_dat_o,
    output logic              upg_done_o,
    output logic              err_o
);

    // Largest legal word count: one full memory.
    localparam logic [16:0] MAX_CNT = 17'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE, S_TGT, S_LEN0, S_LEN1, S_DATA, S_FIN, S_ERR
    } state_e;

    state_e              state_q, state_d;
    logic                tgt_q, tgt_d;
    logic [7:0]          cnt_lo_q, cnt_lo_d;
    logic [15:0]         rem_q, rem_d;
    logic [1:0]          byte_idx_q, byte_idx_d;
    logic [23:0]         asm_q, asm_d;
    logic [ADDR_W-1:0]   word_addr_q, word_addr_d;
    logic                wen_q, wen_d;
    logic [ADDR_W:0]     adr_q, adr_d;
    logic [31:0]         dat_q, dat_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [15:0]         cnt_c;
    logic                hdr_c;

    // A zero timeout would abort every packet; no logic is generated for it.
    if (TIMEOUT_CYC == 0) begin : g_timeout_zero_unsupported
    end

`ifdef UPG_TIMEOUT_EN
    localparam int unsigned GAP_W = $clog2(TIMEOUT_CYC + 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    // Full word count as seen while CNT_H is on the bus.
    assign cnt_c = {rx_data_i, cnt_lo_q};
    // Header acceptance; FIN behaves as IDLE so a byte in that cycle is not lost.
    assign hdr_c = rx_valid_i && (rx_data_i == SYNC_BYTE) &&
                   (state_q == S_IDLE || state_q == S_ERR || state_q == S_FIN);

    // Next-state and output logic.
    always_comb begin
        state_d     = state_q;
        tgt_d       = tgt_q;
        cnt_lo_d    = cnt_lo_q;
        rem_d       = rem_q;
        byte_idx_d  = byte_idx_q;
        asm_d       = asm_q;
        word_addr_d = word_addr_q;
        wen_d       = 1'b0;
        adr_d       = adr_q;
        dat_d       = dat_q;
        done_d      = done_q;
        err_d       = err_q;

        // Address advances in the cycle after the strobe.
        if (wen_q) begin
            word_addr_d = word_addr_q + ADDR_W'(1);
        end

        case (state_q)
            S_TGT: begin
                if (rx_valid_i) begin
                    if (rx_data_i == 8'h00 || rx_data_i == 8'h01) begin
                        tgt_d   = rx_data_i[0];
                        state_d = S_LEN0;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end
                end
            end
            S_LEN0: begin
                if (rx_valid_i) begin
                    cnt_lo_d = rx_data_i;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (rx_valid_i) begin
                    if ({1'b0, cnt_c} > MAX_CNT) begin
                        err_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (cnt_c == 16'd0) begin
                        state_d = S_FIN;
                    end else begin
                        rem_d      = cnt_c;
                        byte_idx_d = 2'd0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (rx_valid_i) begin
                    asm_d      = {asm_q[15:0], rx_data_i};
                    byte_idx_d = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        wen_d = 1'b1;
                        dat_d = {asm_q, rx_data_i};
                        adr_d = {tgt_q, word_addr_q};
                        rem_d = rem_q - 16'd1;
                        if (rem_q == 16'd1) begin
                            state_d = S_FIN;
                        end
                    end
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: ;
        endcase

        // New packet: overrides FIN's done and any sticky error.
        if (hdr_c) begin
            state_d     = S_TGT;
            done_d      = 1'b0;
            err_d       = 1'b0;
            word_addr_d = '0;
            byte_idx_d  = 2'd0;
        end

`ifdef UPG_TIMEOUT_EN
        gap_d = '0;
        if (state_q == S_TGT || state_q == S_LEN0 ||
            state_q == S_LEN1 || state_q == S_DATA) begin
            if (!rx_valid_i) begin
                gap_d = gap_q + GAP_W'(1);
                if (gap_q == GAP_W'(TIMEOUT_CYC - 1)) begin
                    gap_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_ERR;
                end
            end
        end
`endif
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            tgt_q       <= 1'b0;
            cnt_lo_q    <= '0;
            rem_q       <= '0;
            byte_idx_q  <= '0;
            asm_q       <= '0;
            word_addr_q <= '0;
            wen_q       <= 1'b0;
            adr_q       <= '0;
            dat_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            tgt_q       <= tgt_d;
            cnt_lo_q    <= cnt_lo_d;
            rem_q       <= rem_d;
            byte_idx_q  <= byte_idx_d;
            asm_q       <= asm_d;
            word_addr_q <= word_addr_d;
            wen_q       <= wen_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

`ifdef UPG_TIMEOUT_EN
    // Inter-byte gap counter.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end
`endif

    assign upg_wen_o  = wen_q;
    assign upg_adr_o  = adr_q;
    assign upg_dat_o  = dat_q;
    assign upg_done_o = done_q;
    assign err_o      = err_q;

endmodule
